// File: rtl/stepper_monitor_pkg.sv
// ============================================================================
//  stepper_monitor_pkg
//  Coil phase tables and phase-index lookup for the stepper coil monitor.
//  Rev 1.0
// ============================================================================
`default_nettype none

package stepper_monitor_pkg;

    localparam int c_N_FULL = 4;
    localparam int c_N_HALF = 8;
    localparam int c_IDX_W  = 3;

    localparam logic [3:0] c_PAT_IDLE    = 4'b0000;
    localparam logic [3:0] c_PAT_ALL_ON  = 4'b1111;

    // Element [i] is the coil pattern of phase index i.
    localparam logic [c_N_FULL-1:0][3:0] c_TBL_FULL = {
        4'b1000, 4'b0100, 4'b0010, 4'b0001
    };
    localparam logic [c_N_HALF-1:0][3:0] c_TBL_HALF = {
        4'b1001, 4'b1000, 4'b1100, 4'b0100,
        4'b0110, 4'b0010, 4'b0011, 4'b0001
    };

    typedef struct packed {
        logic               valid;
        logic [c_IDX_W-1:0] idx;
    } phase_lookup_t;

    function automatic phase_lookup_t phase_lookup(input logic [3:0] pat,
                                                   input logic       half);
        phase_lookup_t r;
        r = '0;
        if (half) begin
            for (int i = 0; i < c_N_HALF; i++) begin
                if (c_TBL_HALF[i] == pat) begin
                    r.valid = 1'b1;
                    r.idx   = c_IDX_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < c_N_FULL; i++) begin
                if (c_TBL_FULL[i] == pat) begin
                    r.valid = 1'b1;
                    r.idx   = c_IDX_W'(i);
                end
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/coil_pattern_filter.sv
// ============================================================================
//  coil_pattern_filter
//  Synchronises the coil pattern and accepts it once after it has been stable.
//  Rev 1.0
// ============================================================================
`default_nettype none

module coil_pattern_filter #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_coils,
    output logic [3:0] o_pattern,
    output logic       o_accept
);

    localparam int                 c_CNT_W   = $clog2(STABLE_CYCLES) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STABLE_CYCLES - 1);

    logic [3:0]         r_sync1;
    logic [3:0]         r_sync2;
    logic [3:0]         r_cand;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_accept;

    // The counter saturates at its accept value, so a held pattern fires once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_cand   <= '0;
            r_cnt    <= '0;
            r_accept <= 1'b0;
        end else begin
            r_sync1  <= i_coils;
            r_sync2  <= r_sync1;
            r_accept <= 1'b0;
            if (r_sync2 != r_cand) begin
                r_cand   <= r_sync2;
                r_cnt    <= '0;
                r_accept <= (STABLE_CYCLES == 1);
            end else if (r_cnt != c_CNT_MAX) begin
                r_cnt    <= r_cnt + 1'b1;
                r_accept <= ((r_cnt + 1'b1) == c_CNT_MAX);
            end
        end
    end

    assign o_pattern = r_cand;
    assign o_accept  = r_accept;

endmodule

`default_nettype wire

// File: rtl/stepper_coil_monitor.sv
// ============================================================================
//  stepper_coil_monitor
//  Decodes an observed coil pattern into steps, direction, position, period.
//  Rev 1.0
// ============================================================================
`default_nettype none

module stepper_coil_monitor
    import stepper_monitor_pkg::*;
#(
    parameter bit HALF_STEP     = 1'b0,
    parameter int STABLE_CYCLES = 4,
    parameter int POS_W         = 16,
    parameter int PER_W         = 20
) (
    input  logic                    system1000,
    input  logic                    system1000_rst,
    input  logic [3:0]              coils_in,
    input  logic                    clear,
    output logic                    step_pulse,
    output logic                    dir,
    output logic signed [POS_W-1:0] position,
    output logic [PER_W-1:0]        period,
    output logic                    locked,
    output logic                    error
);

    localparam int                 c_N    = HALF_STEP ? c_N_HALF : c_N_FULL;
    localparam logic [c_IDX_W-1:0] c_MASK = c_IDX_W'(c_N - 1);

    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    logic [3:0]          w_pattern;
    logic                w_accept;
    phase_lookup_t       w_lk;
    logic [c_IDX_W-1:0]  w_delta;

    state_t              r_state;
    logic [c_IDX_W-1:0]  r_phase;
    logic                r_step;
    logic                r_dir;
    logic [POS_W-1:0]    r_pos;
    logic [PER_W-1:0]    r_period;
    logic [PER_W-1:0]    r_per_cnt;
    logic                r_locked;
    logic                r_err;

    coil_pattern_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk       (system1000),
        .rst       (system1000_rst),
        .i_coils   (coils_in),
        .o_pattern (w_pattern),
        .o_accept  (w_accept)
    );

    assign w_lk    = phase_lookup(w_pattern, HALF_STEP);
    // Phase distance modulo N; N is a power of two so masking suffices.
    assign w_delta = (w_lk.idx - r_phase) & c_MASK;

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            r_state   <= ST_UNLOCKED;
            r_phase   <= '0;
            r_step    <= 1'b0;
            r_dir     <= 1'b1;
            r_pos     <= '0;
            r_period  <= '1;
            r_per_cnt <= '0;
            r_locked  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_step <= 1'b0;
            if (r_per_cnt != '1) begin
                r_per_cnt <= r_per_cnt + 1'b1;
            end
            if (w_accept && (w_pattern != c_PAT_IDLE)) begin
                if (!w_lk.valid) begin
                    r_err    <= 1'b1;
                    r_state  <= ST_UNLOCKED;
                    r_locked <= 1'b0;
                end else if (r_state == ST_UNLOCKED) begin
                    r_phase  <= w_lk.idx;
                    r_state  <= ST_LOCKED;
                    r_locked <= 1'b1;
                end else if (w_delta == c_IDX_W'(1)) begin
                    r_phase   <= w_lk.idx;
                    r_pos     <= r_pos + 1'b1;
                    r_dir     <= 1'b1;
                    r_step    <= 1'b1;
                    r_period  <= r_per_cnt;
                    r_per_cnt <= PER_W'(1);
                end else if (w_delta == c_MASK) begin
                    r_phase   <= w_lk.idx;
                    r_pos     <= r_pos - 1'b1;
                    r_dir     <= 1'b0;
                    r_step    <= 1'b1;
                    r_period  <= r_per_cnt;
                    r_per_cnt <= PER_W'(1);
                end else if (w_delta != '0) begin
                    r_err   <= 1'b1;
                    r_phase <= w_lk.idx;
                end
            end
            // Clear overrides any position/error update made this cycle.
            if (clear) begin
                r_pos <= '0;
                r_err <= 1'b0;
            end
        end
    end

    assign step_pulse = r_step;
    assign dir        = r_dir;
    assign position   = r_pos;
    assign period     = r_period;
    assign locked     = r_locked;
    assign error      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_stepper_coil_monitor.sv
// ============================================================================
//  tb_stepper_coil_monitor
//  Two monitors (full-step and half-step) against an event-level reference.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_stepper_coil_monitor;

    localparam int C0_S = 4;
    localparam int C0_PW = 5;
    localparam int C0_QW = 10;
    localparam int C1_S = 3;
    localparam int C1_PW = 16;
    localparam int C1_QW = 20;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] coils [2];
    logic clr [2];
    int cyc = 0;

    logic sp0, dir0, lk0, er0;
    logic signed [C0_PW-1:0] pos0;
    logic [C0_QW-1:0] per0;
    logic sp1, dir1, lk1, er1;
    logic signed [C1_PW-1:0] pos1;
    logic [C1_QW-1:0] per1;

    int n_tests = 0;
    int n_fail = 0;

    int m_phase [2];
    int m_locked [2];
    int m_pos [2];
    int m_dir [2];
    int m_err [2];
    int m_last [2];
    longint m_per [2];
    logic [3:0] cur [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stepper_coil_monitor #(
        .HALF_STEP(1'b0), .STABLE_CYCLES(C0_S), .POS_W(C0_PW), .PER_W(C0_QW)
    ) u_fs (
        .system1000(clk), .system1000_rst(rst), .coils_in(coils[0]), .clear(clr[0]),
        .step_pulse(sp0), .dir(dir0), .position(pos0), .period(per0),
        .locked(lk0), .error(er0)
    );

    stepper_coil_monitor #(
        .HALF_STEP(1'b1), .STABLE_CYCLES(C1_S), .POS_W(C1_PW), .PER_W(C1_QW)
    ) u_hs (
        .system1000(clk), .system1000_rst(rst), .coils_in(coils[1]), .clear(clr[1]),
        .step_pulse(sp1), .dir(dir1), .position(pos1), .period(per1),
        .locked(lk1), .error(er1)
    );

    function automatic int s_of(int ch);  return ch == 0 ? C0_S : C1_S; endfunction
    function automatic int n_of(int ch);  return ch == 0 ? 4 : 8; endfunction
    function automatic int pw_of(int ch); return ch == 0 ? C0_PW : C1_PW; endfunction
    function automatic longint qmax_of(int ch);
        return (longint'(1) << (ch == 0 ? C0_QW : C1_QW)) - 1;
    endfunction

    function automatic int tbl(int ch, int i);
        int h [8] = '{1, 3, 2, 6, 4, 12, 8, 9};
        return ch == 0 ? (1 << i) : h[i];
    endfunction

    function automatic int idx_of(int ch, logic [3:0] pat);
        for (int i = 0; i < n_of(ch); i++)
            if (tbl(ch, i) == int'(pat)) return i;
        return -1;
    endfunction

    function automatic int wrap(int ch, int v);
        int h = 1 << (pw_of(ch) - 1);
        return (((v + h) % (2 * h)) + 2 * h) % (2 * h) - h;
    endfunction

    function automatic longint get_sp(int ch);  return ch == 0 ? longint'(sp0) : longint'(sp1); endfunction
    function automatic longint get_dir(int ch); return ch == 0 ? longint'(dir0) : longint'(dir1); endfunction
    function automatic longint get_lk(int ch);  return ch == 0 ? longint'(lk0) : longint'(lk1); endfunction
    function automatic longint get_er(int ch);  return ch == 0 ? longint'(er0) : longint'(er1); endfunction
    function automatic longint get_pos(int ch); return ch == 0 ? longint'(pos0) : longint'(pos1); endfunction
    function automatic longint get_per(int ch); return ch == 0 ? longint'(per0) : longint'(per1); endfunction

    task automatic check(input string tag, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_state(input int ch, input string tag);
        check({tag, ".position"}, get_pos(ch), longint'(m_pos[ch]));
        check({tag, ".dir"},      get_dir(ch), longint'(m_dir[ch]));
        check({tag, ".locked"},   get_lk(ch),  longint'(m_locked[ch]));
        check({tag, ".error"},    get_er(ch),  longint'(m_err[ch]));
        check({tag, ".period"},   get_per(ch), m_per[ch]);
    endtask

    // Reference reaction to an accepted pattern, evaluated at the step edge.
    task automatic do_effect(input int ch, input logic [3:0] pat, output bit stepped);
        int n = n_of(ch);
        int ix = idx_of(ch, pat);
        int d;
        stepped = 1'b0;
        if (pat == 4'b0000) return;
        if (ix < 0) begin
            m_err[ch] = 1; m_locked[ch] = 0;
            return;
        end
        if (m_locked[ch] == 0) begin
            m_phase[ch] = ix; m_locked[ch] = 1;
            return;
        end
        d = (ix - m_phase[ch] + n) % n;
        if (d == 0) return;
        m_phase[ch] = ix;
        if (d == 1 || d == n - 1) begin
            m_pos[ch] = wrap(ch, m_pos[ch] + (d == 1 ? 1 : -1));
            m_dir[ch] = (d == 1) ? 1 : 0;
            m_per[ch] = (longint'(cyc - m_last[ch]) > qmax_of(ch)) ? qmax_of(ch)
                                                                    : longint'(cyc - m_last[ch]);
            m_last[ch] = cyc;
            stepped = 1'b1;
        end else begin
            m_err[ch] = 1;
        end
    endtask

    task automatic reset_all();
        coils[0] = 4'b0; coils[1] = 4'b0; clr[0] = 1'b0; clr[1] = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            m_phase[c] = 0; m_locked[c] = 0; m_pos[c] = 0; m_dir[c] = 1;
            m_err[c] = 0; m_per[c] = qmax_of(c); m_last[c] = cyc + 1; cur[c] = 4'b0;
        end
    endtask

    task automatic apply(input int ch, input logic [3:0] pat, input int hold_in, input int clr_at);
        int st = s_of(ch) + 3;
        int hold = (hold_in < st) ? st : hold_in;
        bit stepped;
        bit exp_pulse;
        coils[ch] = pat;
        cur[ch] = pat;
        for (int k = 1; k <= hold; k++) begin
            clr[ch] = (k == clr_at);
            @(posedge clk);
            #1;
            clr[ch] = 1'b0;
            exp_pulse = 1'b0;
            if (k == st) begin
                do_effect(ch, pat, stepped);
                exp_pulse = stepped;
            end
            if (k == clr_at) begin
                m_pos[ch] = 0; m_err[ch] = 0;
            end
            check("step_pulse", get_sp(ch), longint'(exp_pulse));
        end
        check_state(ch, "apply");
    endtask

    task automatic glitch(input int ch, input logic [3:0] gpat, input int len);
        logic [3:0] restore = cur[ch];
        bit stepped;
        coils[ch] = gpat;
        repeat (len) begin
            @(posedge clk); #1;
            check("glitch_pulse", get_sp(ch), 0);
        end
        coils[ch] = restore;
        repeat (s_of(ch) + 4) begin
            @(posedge clk); #1;
            check("glitch_pulse", get_sp(ch), 0);
        end
        do_effect(ch, restore, stepped);
        check_state(ch, "glitch");
    endtask

    task automatic step_fwd(input int ch, input int hold, input int clr_at);
        apply(ch, 4'(tbl(ch, (m_phase[ch] + 1) % n_of(ch))), hold, clr_at);
    endtask

    task automatic rand_run(input int ch, input int iters);
        int n = n_of(ch);
        int st = s_of(ch) + 3;
        for (int it = 0; it < iters; it++) begin
            int r = int'($urandom % 100);
            int d = -1;
            logic [3:0] pat;
            int hold;
            int ca = 0;
            if (r < 40)      d = 1;
            else if (r < 65) d = n - 1;
            else if (r < 72) d = int'($urandom_range(2, n - 2));
            if (d > 0) begin
                pat = 4'(tbl(ch, (m_phase[ch] + d) % n));
            end else if (r < 82) begin
                do pat = 4'($urandom % 16); while (pat == 4'b0 || idx_of(ch, pat) >= 0);
            end else if (r < 88) begin
                pat = 4'b0;
            end else begin
                do pat = 4'($urandom % 16); while (pat == cur[ch]);
                glitch(ch, pat, int'($urandom_range(1, s_of(ch) - 1)));
                continue;
            end
            if (pat == cur[ch]) continue;
            hold = ($urandom % 10 == 0) ? 150 : int'($urandom_range(st, st + 12));
            if ($urandom % 6 == 0)
                ca = ($urandom % 2 == 0) ? st : int'($urandom_range(1, hold));
            apply(ch, pat, hold, ca);
        end
    endtask

    initial begin
        reset_all();
        check_state(0, "reset0");
        check_state(1, "reset1");
        check("reset_pulse0", get_sp(0), 0);

        // Full-step forward then reverse
        apply(0, 4'b0001, 10, 0);
        apply(0, 4'b0010, 10, 0);
        apply(0, 4'b0100, 10, 0);
        apply(0, 4'b1000, 10, 0);
        apply(0, 4'b0001, 10, 0);
        check("fwd4_pos", get_pos(0), 4);
        apply(0, 4'b1000, 10, 0);
        apply(0, 4'b0100, 10, 0);
        check("rev2_dir", get_dir(0), 0);

        // Exact period
        step_fwd(0, 100, 0);
        step_fwd(0, 100, 0);
        check("period100", get_per(0), 100);

        // Position wrap, then clear coinciding with a step
        repeat (20) step_fwd(0, 8, 0);
        step_fwd(0, 8, C0_S + 3);
        check("clear_pos", get_pos(0), 0);

        // Period saturation across a long idle gap
        apply(0, 4'b0000, 1100, 0);
        step_fwd(0, 8, 0);
        check("period_sat", get_per(0), qmax_of(0));

        // Half-step sweep and skip
        apply(1, 4'b0001, 8, 0);
        for (int i = 1; i <= 8; i++) apply(1, 4'(tbl(1, i % 8)), 8, 0);
        check("half_pos8", get_pos(1), 8);
        apply(1, 4'b0100, 8, 0);
        check("skip_err", get_er(1), 1);
        check("skip_pos", get_pos(1), 8);

        // Glitch, illegal pattern, relock
        apply(1, 4'b0010, 8, 0);
        glitch(1, 4'b0110, 1);
        apply(1, 4'b0111, 8, 0);
        check("illegal_unlock", get_lk(1), 0);
        apply(1, 4'b0010, 8, 0);
        check("relock", get_lk(1), 1);

        rand_run(0, 80);
        rand_run(1, 80);

        // Reset mid-operation then relock without a step
        reset_all();
        check_state(0, "rst_mid0");
        check_state(1, "rst_mid1");
        apply(0, 4'b0010, 10, 0);
        apply(1, 4'b0110, 10, 0);

        rand_run(0, 60);
        rand_run(1, 60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
